// File: rtl/memguard_dispatcher.sv
// Dispatcher that pops one word from the scheduler-selected queue, presents it
// downstream with valid/ready, then pulses update and bumps that queue's served counter.
module memguard_dispatcher #(
    parameter int NUMBER_OF_QUEUES = 4,
    parameter int DATA_WIDTH       = 32,
    parameter int COUNTER_SIZE     = 16
) (
    input  logic                                     clock,
    input  logic                                     reset,
    input  logic                                     sched_valid,
    input  logic [$clog2(NUMBER_OF_QUEUES)-1:0]      sched_selection,
    input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0]   queue_data,
    input  logic [NUMBER_OF_QUEUES-1:0]              empty,
    output logic [NUMBER_OF_QUEUES-1:0]              pop,
    output logic                                     m_valid,
    input  logic                                     m_ready,
    output logic [DATA_WIDTH-1:0]                    m_data,
    output logic [$clog2(NUMBER_OF_QUEUES)-1:0]      m_source,
    output logic                                     update,
    output logic                                     busy,
    output logic [NUMBER_OF_QUEUES*COUNTER_SIZE-1:0] served
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SEND = 2'd1;
    localparam logic [1:0] GAP  = 2'd2;

    logic [1:0]              state;
    logic [DATA_WIDTH-1:0]   head      [NUMBER_OF_QUEUES];
    logic [COUNTER_SIZE-1:0] served_q  [NUMBER_OF_QUEUES];
    logic                    sel_in_range;
    logic                    accept;

    for (genvar g = 0; g < NUMBER_OF_QUEUES; g++) begin : g_lane
        assign head[g] = queue_data[g*DATA_WIDTH +: DATA_WIDTH];
        assign served[g*COUNTER_SIZE +: COUNTER_SIZE] = served_q[g];
    end

    // Guards non-power-of-two queue counts against out-of-range selections.
    assign sel_in_range = (int'(sched_selection) < NUMBER_OF_QUEUES);

    // Reset gates the accept so pop is forced low even while rst is held.
    assign accept = reset && (state == IDLE) && sched_valid && sel_in_range
                    && !empty[sched_selection];

    always_comb begin
        pop = '0;
        if (accept) begin
            pop[sched_selection] = 1'b1;
        end
    end

    assign m_valid = (state == SEND);
    assign busy    = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            m_data   <= '0;
            m_source <= '0;
            update   <= 1'b0;
            for (int i = 0; i < NUMBER_OF_QUEUES; i++) begin
                served_q[i] <= '0;
            end
        end else begin
            update <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        m_data   <= head[sched_selection];
                        m_source <= sched_selection;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (m_ready) begin
                        state  <= GAP;
                        update <= 1'b1;
                        // Saturate rather than wrap so a stuck-high count stays visible.
                        if (served_q[m_source] != '1) begin
                            served_q[m_source] <= served_q[m_source] + 1'b1;
                        end
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memguard_dispatcher.sv
// Scoreboard bench for memguard_dispatcher: stimulus queues expected transactions,
// a negedge monitor checks every downstream handshake and the update/served that follows.
module tb_memguard_dispatcher;

    localparam int NQ = 4;
    localparam int DW = 32;
    localparam int CS = 2;

    logic             clock = 1'b0;
    logic             reset;
    logic             sched_valid;
    logic [1:0]       sched_selection;
    logic [NQ*DW-1:0] queue_data;
    logic [NQ-1:0]    empty;
    logic [NQ-1:0]    pop;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic [1:0]       m_source;
    logic             update;
    logic             busy;
    logic [NQ*CS-1:0] served;

    memguard_dispatcher #(
        .NUMBER_OF_QUEUES(NQ),
        .DATA_WIDTH      (DW),
        .COUNTER_SIZE    (CS)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sched_valid    (sched_valid),
        .sched_selection(sched_selection),
        .queue_data     (queue_data),
        .empty          (empty),
        .pop            (pop),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .m_data         (m_data),
        .m_source       (m_source),
        .update         (update),
        .busy           (busy),
        .served         (served)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  src;
        logic [1:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   upd_cyc[$];
    int   checks    = 0;
    int   failures  = 0;
    int   pop_count = 0;
    int   upd_count = 0;
    int   cyc       = 0;
    logic       pend = 1'b0;
    logic [1:0] pend_src;
    logic [1:0] pend_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [1:0] lane(input logic [1:0] idx);
        return served[idx*CS +: CS];
    endfunction

    function automatic logic [31:0] word(input int i);
        return 32'hCAFE0000 + 32'(i);
    endfunction

    task automatic load_queues();
        for (int i = 0; i < NQ; i++) queue_data[i*DW +: DW] = word(i);
    endtask

    task automatic do_reset();
        reset       = 1'b0;
        sched_valid = 1'b0;
        m_ready     = 1'b0;
        sb.delete();
        upd_cyc.delete();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Monitor: peeks the scoreboard head on every valid cycle, retires it on the update pulse.
    always @(negedge clock) begin
        cyc++;
        if (!reset) begin
            pend = 1'b0;
        end else begin
            if (pop != '0) begin
                pop_count++;
                check("pop_onehot", 64'($onehot(pop)), 64'd1);
            end
            if (update) begin
                upd_count++;
                upd_cyc.push_back(cyc);
            end
            if (pend) begin
                check("update_after_handshake", 64'(update), 64'd1);
                check("served_after_txn", 64'(lane(pend_src)), 64'(pend_cnt));
                if (sb.size() != 0) void'(sb.pop_front());
                pend = 1'b0;
            end else if (update) begin
                check("update_spurious", 64'(update), 64'd0);
            end
            if (m_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL m_valid_unexpected actual=%0h required=none", m_data);
                end else begin
                    check("m_data", 64'(m_data), 64'(sb[0].data));
                    check("m_source", 64'(m_source), 64'(sb[0].src));
                    if (m_ready) begin
                        pend     = 1'b1;
                        pend_src = sb[0].src;
                        pend_cnt = sb[0].cnt;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int u0;
        reset           = 1'b0;
        sched_valid     = 1'b1;
        sched_selection = 2'd2;
        empty           = '0;
        m_ready         = 1'b1;
        load_queues();

        // Reset state, with an otherwise acceptable request present.
        #3;
        check("reset_pop", 64'(pop), 64'd0);
        check("reset_m_valid", 64'(m_valid), 64'd0);
        check("reset_m_data", 64'(m_data), 64'd0);
        check("reset_m_source", 64'(m_source), 64'd0);
        check("reset_update", 64'(update), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_served", 64'(served), 64'd0);
        do_reset();

        // Basic transaction on queue 2.
        p0 = pop_count;
        sched_valid = 1'b1; sched_selection = 2'd2; m_ready = 1'b1;
        sb.push_back('{data: 32'hCAFE0002, src: 2'd2, cnt: 2'd1});
        #1;
        check("basic_pop", 64'(pop), 64'b0100);
        tick();
        sched_valid = 1'b0;
        check("basic_m_valid", 64'(m_valid), 64'd1);
        check("basic_pop_send", 64'(pop), 64'd0);
        tick();
        check("basic_update", 64'(update), 64'd1);
        check("basic_busy_gap", 64'(busy), 64'd1);
        check("basic_served2", 64'(lane(2'd2)), 64'd1);
        tick();
        check("basic_idle_busy", 64'(busy), 64'd0);
        check("basic_idle_update", 64'(update), 64'd0);
        tick();
        check("basic_pop_count", 64'(pop_count - p0), 64'd1);

        // Backpressure, with selection/data/empty disturbed mid-transaction.
        do_reset();
        p0 = pop_count;
        sched_valid = 1'b1; sched_selection = 2'd2; m_ready = 1'b0;
        sb.push_back('{data: 32'hCAFE0002, src: 2'd2, cnt: 2'd1});
        tick();
        sched_selection = 2'd1;
        queue_data[2*DW +: DW] = 32'hDEAD0002;
        empty = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            check("bp_m_valid", 64'(m_valid), 64'd1);
            check("bp_update_low", 64'(update), 64'd0);
            tick();
        end
        m_ready = 1'b1;
        check("bp_m_valid_6", 64'(m_valid), 64'd1);
        check("bp_update_before", 64'(update), 64'd0);
        sched_valid = 1'b0;
        tick();
        check("bp_update", 64'(update), 64'd1);
        tick();
        check("bp_pop_count", 64'(pop_count - p0), 64'd1);
        empty = '0;
        load_queues();

        // Empty guard.
        u0 = upd_count;
        sched_valid = 1'b1; sched_selection = 2'd1; empty = 4'b0010;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("empty_pop", 64'(pop), 64'd0);
            check("empty_busy", 64'(busy), 64'd0);
            tick();
        end
        check("empty_no_update", 64'(upd_count - u0), 64'd0);
        sched_valid = 1'b0; empty = '0;

        // Back-to-back: selection alternating 0/3 every cycle for 9 cycles.
        do_reset();
        p0 = pop_count; u0 = upd_count;
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd1});
        sb.push_back('{data: 32'hCAFE0003, src: 2'd3, cnt: 2'd1});
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd2});
        sched_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            sched_selection = (i % 2 == 0) ? 2'd0 : 2'd3;
            tick();
        end
        sched_valid = 1'b0;
        tick();
        check("b2b_pops", 64'(pop_count - p0), 64'd3);
        check("b2b_updates", 64'(upd_count - u0), 64'd3);
        check("b2b_served_sum", 64'(lane(2'd0) + lane(2'd3)), 64'd3);
        if (upd_cyc.size() == 3) begin
            check("b2b_gap_1", 64'(upd_cyc[1] - upd_cyc[0]), 64'd3);
            check("b2b_gap_2", 64'(upd_cyc[2] - upd_cyc[1]), 64'd3);
        end else begin
            check("b2b_update_list", 64'(upd_cyc.size()), 64'd3);
        end

        // Saturation of a 2-bit counter over 5 transactions on queue 0.
        do_reset();
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd1});
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd2});
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd3});
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd3});
        sb.push_back('{data: 32'hCAFE0000, src: 2'd0, cnt: 2'd3});
        sched_valid = 1'b1; sched_selection = 2'd0; m_ready = 1'b1;
        for (int i = 0; i < 15; i++) tick();
        sched_valid = 1'b0;
        tick();
        check("sat_served0", 64'(lane(2'd0)), 64'd3);
        check("sat_sb_drained", 64'(sb.size()), 64'd0);

        // Reset in the middle of SEND after one completed transaction.
        do_reset();
        sb.push_back('{data: 32'hCAFE0003, src: 2'd3, cnt: 2'd1});
        sched_valid = 1'b1; sched_selection = 2'd3; m_ready = 1'b1;
        tick();
        sched_valid = 1'b0;
        tick();
        tick();
        check("rs_served3_before", 64'(lane(2'd3)), 64'd1);
        sb.push_back('{data: 32'hCAFE0001, src: 2'd1, cnt: 2'd1});
        sched_valid = 1'b1; sched_selection = 2'd1; m_ready = 1'b0;
        tick();
        sched_valid = 1'b0;
        check("rs_m_valid_before", 64'(m_valid), 64'd1);
        u0 = upd_count;
        reset = 1'b0;
        sb.delete();
        #1;
        check("rs_m_valid", 64'(m_valid), 64'd0);
        check("rs_update", 64'(update), 64'd0);
        check("rs_busy", 64'(busy), 64'd0);
        check("rs_served", 64'(served), 64'd0);
        tick();
        tick();
        reset = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_idle_busy", 64'(busy), 64'd0);
            check("rs_idle_m_valid", 64'(m_valid), 64'd0);
        end
        check("rs_no_update", 64'(upd_count - u0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
